// File: rtl/zmc_rom_reader_pkg.sv
// Shared types and constants for the Z80 banked-ROM reader.
// Holds the FSM encoding, address widths and the byte-lane select helper.
package zmc_rom_reader_pkg;

  localparam int BYTE_ADDR_W = 19;
  localparam int WORD_TAG_W  = 18;
  localparam int TMO_W       = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOOKUP,
    S_FETCH,
    S_DONE
  } state_e;

  function automatic logic [7:0] byte_sel(
    input logic [15:0] w,
    input logic        b0
  );
    return b0 ? w[15:8] : w[7:0];
  endfunction

endpackage

// File: rtl/zmc_word_cache.sv
// Single-entry word cache: tag, data and valid with fill, flush and compare.
// A flush in the same cycle as a fill leaves the entry invalid.
import zmc_rom_reader_pkg::*;

module zmc_word_cache (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_i,
  input  logic                  flush_i,
  input  logic [WORD_TAG_W-1:0] fill_tag_i,
  input  logic [15:0]           fill_word_i,
  input  logic [WORD_TAG_W-1:0] cmp_tag_i,
  output logic                  hit_o,
  output logic [15:0]           word_o
);

  logic                  valid_q, valid_d;
  logic [WORD_TAG_W-1:0] tag_q, tag_d;
  logic [15:0]           word_q, word_d;

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    word_d  = word_q;
    if (fill_i) begin
      valid_d = 1'b1;
      tag_d   = fill_tag_i;
      word_d  = fill_word_i;
    end
    if (flush_i) valid_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      tag_q   <= '0;
      word_q  <= '0;
    end else begin
      valid_q <= valid_d;
      tag_q   <= tag_d;
      word_q  <= word_d;
    end
  end

  assign hit_o  = valid_q & (tag_q == cmp_tag_i);
  assign word_o = word_q;

endmodule

// File: rtl/zmc_rom_reader.sv
// Z80 M1 ROM responder: one-word cache in front of an SDRAM read port.
// Stalls the Z80 with nZ80WAIT on a miss; a stuck fetch times out to ERR.
import zmc_rom_reader_pkg::*;

module zmc_rom_reader #(
  parameter int          TIMEOUT_CYCLES = 255,
  parameter logic [23:0] ROM_BASE       = 24'h0
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        nSDROM,
  input  logic [7:0]  MA,
  input  logic [10:0] SDA_L,
  input  logic        FLUSH,
  output logic [7:0]  SDD_OUT,
  output logic        nZ80WAIT,
  output logic        ROM_REQ,
  output logic [23:0] ROM_ADDR,
  input  logic        ROM_ACK,
  input  logic [15:0] ROM_DATA,
  output logic        ERR
);

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  state_e                 state_q, state_d;
  logic                   nsdrom_q;
  logic [BYTE_ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]             sdd_q, sdd_d;
  logic                   wait_q, wait_d;
  logic                   req_q, req_d;
  logic [23:0]            raddr_q, raddr_d;
  logic                   err_q, err_d;
  logic [TMO_W-1:0]       cnt_q, cnt_d;

  logic        fall;
  logic        fill;
  logic        inval;
  logic        hit;
  logic [15:0] c_word;

  assign fall = nsdrom_q & ~nSDROM;

  zmc_word_cache u_cache (
    .clk         (CLK),
    .rst         (RESET),
    .fill_i      (fill),
    .flush_i     (inval),
    .fill_tag_i  (addr_q[BYTE_ADDR_W-1:1]),
    .fill_word_i (ROM_DATA),
    .cmp_tag_i   (addr_q[BYTE_ADDR_W-1:1]),
    .hit_o       (hit),
    .word_o      (c_word)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    sdd_d   = sdd_q;
    wait_d  = wait_q;
    req_d   = req_q;
    raddr_d = raddr_q;
    err_d   = err_q;
    cnt_d   = cnt_q;
    fill    = 1'b0;
    inval   = FLUSH;
    case (state_q)
      S_IDLE: begin
        if (fall) begin
          addr_d  = {MA, SDA_L};
          state_d = S_LOOKUP;
        end
      end
      S_LOOKUP: begin
        if (hit && !FLUSH) begin
          sdd_d   = byte_sel(c_word, addr_q[0]);
          state_d = S_DONE;
        end else begin
          req_d   = 1'b1;
          raddr_d = ROM_BASE + {6'b0, addr_q[BYTE_ADDR_W-1:1]};
          wait_d  = 1'b0;
          cnt_d   = '0;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (ROM_ACK) begin
          fill    = 1'b1;
          sdd_d   = byte_sel(ROM_DATA, addr_q[0]);
          req_d   = 1'b0;
          wait_d  = 1'b1;
          state_d = S_DONE;
        end else if (cnt_q == TMO_LAST) begin
          // Give up: release the Z80 with open-bus data and drop the entry.
          req_d   = 1'b0;
          sdd_d   = 8'hFF;
          wait_d  = 1'b1;
          err_d   = 1'b1;
          inval   = 1'b1;
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE: begin
        if (nsdrom_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= S_IDLE;
      nsdrom_q <= 1'b1;
      addr_q   <= '0;
      sdd_q    <= 8'hFF;
      wait_q   <= 1'b1;
      req_q    <= 1'b0;
      raddr_q  <= ROM_BASE;
      err_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      nsdrom_q <= nSDROM;
      addr_q   <= addr_d;
      sdd_q    <= sdd_d;
      wait_q   <= wait_d;
      req_q    <= req_d;
      raddr_q  <= raddr_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
    end
  end

  assign SDD_OUT  = sdd_q;
  assign nZ80WAIT = wait_q;
  assign ROM_REQ  = req_q;
  assign ROM_ADDR = raddr_q;
  assign ERR      = err_q;

endmodule

// File: tb/tb_zmc_rom_reader.sv
// Directed bench for zmc_rom_reader: miss, hit, flush race, timeout,
// aborted strobe and reset during a fetch.
module tb_zmc_rom_reader;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        nSDROM;
  logic [7:0]  MA;
  logic [10:0] SDA_L;
  logic        FLUSH;
  logic [7:0]  SDD_OUT;
  logic        nZ80WAIT;
  logic        ROM_REQ;
  logic [23:0] ROM_ADDR;
  logic        ROM_ACK;
  logic [15:0] ROM_DATA;
  logic        ERR;

  int n_chk  = 0;
  int n_pass = 0;

  zmc_rom_reader dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .nSDROM   (nSDROM),
    .MA       (MA),
    .SDA_L    (SDA_L),
    .FLUSH    (FLUSH),
    .SDD_OUT  (SDD_OUT),
    .nZ80WAIT (nZ80WAIT),
    .ROM_REQ  (ROM_REQ),
    .ROM_ADDR (ROM_ADDR),
    .ROM_ACK  (ROM_ACK),
    .ROM_DATA (ROM_DATA),
    .ERR      (ERR)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Strobe falls now; LOOKUP result is visible after two edges.
  task automatic access(input logic [7:0] ma, input logic [10:0] a);
    MA     = ma;
    SDA_L  = a;
    nSDROM = 1'b0;
    tick(2);
  endtask

  task automatic ack(input logic [15:0] d, input logic fl = 1'b0);
    ROM_ACK  = 1'b1;
    ROM_DATA = d;
    FLUSH    = fl;
    tick();
    ROM_ACK  = 1'b0;
    FLUSH    = 1'b0;
  endtask

  task automatic release_strobe();
    nSDROM = 1'b1;
    tick(3);
  endtask

  initial begin
    int n;
    RESET    = 1'b1;
    nSDROM   = 1'b1;
    MA       = '0;
    SDA_L    = '0;
    FLUSH    = 1'b0;
    ROM_ACK  = 1'b0;
    ROM_DATA = '0;
    tick(2);
    RESET = 1'b0;
    tick();
    check("rst_sdd",  SDD_OUT,  8'hFF);
    check("rst_wait", nZ80WAIT, 1'b1);
    check("rst_req",  ROM_REQ,  1'b0);
    check("rst_addr", ROM_ADDR, 24'h0);
    check("rst_err",  ERR,      1'b0);

    // Cold miss: {1E,005} -> word {1E,002} = 0x7802
    access(8'h1E, 11'h005);
    check("miss_wait", nZ80WAIT, 1'b0);
    check("miss_req",  ROM_REQ,  1'b1);
    check("miss_addr", ROM_ADDR, 24'h007802);
    tick(5);
    check("miss_hold_req",  ROM_REQ,  1'b1);
    check("miss_hold_addr", ROM_ADDR, 24'h007802);
    ack(16'hBEEF);
    check("miss_sdd",  SDD_OUT,  8'hBE);
    check("miss_wrel", nZ80WAIT, 1'b1);
    check("miss_rdrop", ROM_REQ, 1'b0);
    release_strobe();

    // Hit on the other byte of the same word
    MA     = 8'h1E;
    SDA_L  = 11'h004;
    nSDROM = 1'b0;
    tick();
    check("hit_req1",  ROM_REQ,  1'b0);
    check("hit_wait1", nZ80WAIT, 1'b1);
    tick();
    check("hit_sdd",  SDD_OUT,  8'hEF);
    check("hit_req2", ROM_REQ,  1'b0);
    check("hit_wait2", nZ80WAIT, 1'b1);
    release_strobe();

    // Flush collides with the fill: entry must stay invalid
    access(8'h22, 11'h010);
    check("fl_addr", ROM_ADDR, 24'h008808);
    ack(16'hCAFE, 1'b1);
    check("fl_sdd", SDD_OUT, 8'hFE);
    release_strobe();
    access(8'h22, 11'h010);
    check("fl_remiss", ROM_REQ, 1'b1);
    ack(16'hCAFE);
    release_strobe();

    // Strobe aborted mid-fetch: fill still lands, then a hit
    access(8'h05, 11'h100);
    check("ab_addr", ROM_ADDR, 24'h001480);
    tick(2);
    nSDROM = 1'b1;
    tick();
    ack(16'h1234);
    check("ab_sdd", SDD_OUT, 8'h34);
    tick(2);
    access(8'h05, 11'h100);
    check("ab_hit_req", ROM_REQ, 1'b0);
    check("ab_hit_sdd", SDD_OUT, 8'h34);
    release_strobe();

    // Timeout: no ack ever
    access(8'h40, 11'h000);
    check("to_req", ROM_REQ, 1'b1);
    n = 0;
    while (ROM_REQ && n < 400) begin
      tick();
      n++;
    end
    check("to_cycles", n, 255);
    check("to_sdd",  SDD_OUT,  8'hFF);
    check("to_wait", nZ80WAIT, 1'b1);
    check("to_err",  ERR,      1'b1);
    release_strobe();
    access(8'h40, 11'h001);
    check("to_remiss", ROM_REQ, 1'b1);
    ack(16'h5A5A);
    check("to_good_sdd", SDD_OUT, 8'h5A);
    check("to_err_sticky", ERR, 1'b1);
    release_strobe();

    // Reset during a fetch, then a late ack must not fill
    access(8'h33, 11'h222);
    check("rf_req", ROM_REQ, 1'b1);
    tick();
    RESET  = 1'b1;
    nSDROM = 1'b1;
    tick();
    RESET = 1'b0;
    check("rf_req_drop", ROM_REQ,  1'b0);
    check("rf_sdd",      SDD_OUT,  8'hFF);
    check("rf_wait",     nZ80WAIT, 1'b1);
    check("rf_err_clr",  ERR,      1'b0);
    ack(16'h7777);
    tick();
    access(8'h33, 11'h222);
    check("rf_remiss", ROM_REQ, 1'b1);
    ack(16'h7777);
    release_strobe();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
